// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC update modes and the default reset vector.
package cpu_pkg;

    // PC update mode driven by cpu_control; codes 5..7 behave as Same.
    typedef enum logic [2:0] {
        PcNextSame = 3'd0,
        PcNextInc  = 3'd1,
        PcNextDec  = 3'd2,
        PcNextLoad = 3'd3,
        PcNextRel  = 3'd4
    } pc_next_e;

    // Default program counter value after reset.
    localparam logic [15:0] CPU_RESET_PC = 16'h0000;

endpackage

// File: rtl/cpu_fetch_sequencer_if.sv
// Control and bus signals of the fetch sequencer. The master side is
// cpu_control plus the system bus; the slave side is the sequencer.
interface cpu_fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int T_PER_M    = 4
);
    // Driven towards the sequencer
    logic [2:0]                  pc_next;
    logic [ADDR_WIDTH-1:0]       pc_load_value;
    logic [DATA_WIDTH-1:0]       pc_rel_offset;
    logic                        inst_load;
    logic                        halt;
    logic                        mem_ready;
    logic [DATA_WIDTH-1:0]       mem_data_in;

    // Produced by the sequencer
    logic [$clog2(T_PER_M)-1:0]  t_cycle;
    logic                        clk_phi;
    logic                        m_cycle_end;
    logic                        wait_state;
    logic [ADDR_WIDTH-1:0]       pc;
    logic [DATA_WIDTH-1:0]       instruction_register;
    logic                        inst_valid;

    modport master (
        output pc_next, pc_load_value, pc_rel_offset, inst_load, halt,
               mem_ready, mem_data_in,
        input  t_cycle, clk_phi, m_cycle_end, wait_state, pc,
               instruction_register, inst_valid
    );

    modport slave (
        input  pc_next, pc_load_value, pc_rel_offset, inst_load, halt,
               mem_ready, mem_data_in,
        output t_cycle, clk_phi, m_cycle_end, wait_state, pc,
               instruction_register, inst_valid
    );
endinterface

// File: rtl/cpu_tcycle_counter.sv
// T-cycle phase counter. Stretches the last T-cycle while the bus is not
// ready and flags the clock on which the M-cycle completes.
module cpu_tcycle_counter #(
    parameter int T_PER_M = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_ready,
    output logic [$clog2(T_PER_M)-1:0]  t_cycle,
    output logic                        clk_phi,
    output logic                        m_cycle_end,
    output logic                        wait_state
);
    localparam int T_W = $clog2(T_PER_M);
    localparam logic [T_W-1:0] T_LAST = T_W'(T_PER_M - 1);
    localparam logic [T_W-1:0] T_HALF = T_W'(T_PER_M / 2);

    logic [T_W-1:0] t_cycle_reg;
    logic [T_W-1:0] t_cycle_next;
    logic           last_t;

    assign last_t      = (t_cycle_reg == T_LAST);
    assign m_cycle_end = last_t && mem_ready;
    assign wait_state  = last_t && !mem_ready;
    assign clk_phi     = (t_cycle_reg < T_HALF);
    assign t_cycle     = t_cycle_reg;

    // Advance, wrap on a completed M-cycle, or hold on the last T-cycle.
    always_comb begin
        t_cycle_next = t_cycle_reg + T_W'(1);
        if (last_t) begin
            t_cycle_next = mem_ready ? '0 : t_cycle_reg;
        end
    end

    // Phase register; reset restarts the M-cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            t_cycle_reg <= '0;
        end else begin
            t_cycle_reg <= t_cycle_next;
        end
    end
endmodule

// File: rtl/cpu_fetch_sequencer.sv
// M-cycle sequencer with the PC and instruction register. PC and IR update
// only on the commit edge of a completed M-cycle, unless halted.
module cpu_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    T_PER_M    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = CPU_RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_fetch_sequencer_if.slave bus
);
    logic                        m_cycle_end;
    logic [$clog2(T_PER_M)-1:0]  t_cycle;
    logic                        clk_phi;
    logic                        wait_state;

    logic [ADDR_WIDTH-1:0]       pc_reg;
    logic [ADDR_WIDTH-1:0]       pc_value_next;
    logic [ADDR_WIDTH-1:0]       rel_ext;
    logic [DATA_WIDTH-1:0]       ir_reg;
    logic                        inst_valid_reg;

    cpu_tcycle_counter #(
        .T_PER_M (T_PER_M)
    ) u_tcycle (
        .clk         (clk),
        .reset       (reset),
        .mem_ready   (bus.mem_ready),
        .t_cycle     (t_cycle),
        .clk_phi     (clk_phi),
        .m_cycle_end (m_cycle_end),
        .wait_state  (wait_state)
    );

    // Sign-extend the relative offset to address width.
    assign rel_ext = {{(ADDR_WIDTH - DATA_WIDTH){bus.pc_rel_offset[DATA_WIDTH-1]}},
                      bus.pc_rel_offset};

    // Next-PC mux; all arithmetic wraps at the address width.
    always_comb begin
        pc_value_next = pc_reg;
        case (bus.pc_next)
            PcNextInc:  pc_value_next = pc_reg + ADDR_WIDTH'(1);
            PcNextDec:  pc_value_next = pc_reg - ADDR_WIDTH'(1);
            PcNextLoad: pc_value_next = bus.pc_load_value;
            PcNextRel:  pc_value_next = pc_reg + rel_ext;
            default:    pc_value_next = pc_reg;
        endcase
    end

    // PC / IR commit; reset wins over a pending commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            ir_reg         <= '0;
            inst_valid_reg <= 1'b0;
        end else if (m_cycle_end && !bus.halt) begin
            pc_reg <= pc_value_next;
            if (bus.inst_load) begin
                ir_reg         <= bus.mem_data_in;
                inst_valid_reg <= 1'b1;
            end
        end
    end

    assign bus.t_cycle              = t_cycle;
    assign bus.clk_phi              = clk_phi;
    assign bus.m_cycle_end          = m_cycle_end;
    assign bus.wait_state           = wait_state;
    assign bus.pc                   = pc_reg;
    assign bus.instruction_register = ir_reg;
    assign bus.inst_valid           = inst_valid_reg;
endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Directed testbench for cpu_fetch_sequencer with hand-computed expectations.
module tb_cpu_fetch_sequencer;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cpu_fetch_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .T_PER_M(4)) bus ();

    cpu_fetch_sequencer #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .T_PER_M    (4),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One nominal M-cycle from t_cycle 0, inputs held for the whole cycle.
    task automatic mcycle(input logic [2:0] mode, input logic [15:0] ld,
                          input logic [7:0] rel, input logic il,
                          input logic [7:0] data, input logic hl);
        bus.pc_next       = mode;
        bus.pc_load_value = ld;
        bus.pc_rel_offset = rel;
        bus.inst_load     = il;
        bus.mem_data_in   = data;
        bus.halt          = hl;
        bus.mem_ready     = 1'b1;
        repeat (4) tick();
        bus.inst_load = 1'b0;
        bus.halt      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int clocks;
        bus.pc_next       = PcNextInc;
        bus.pc_load_value = '0;
        bus.pc_rel_offset = '0;
        bus.inst_load     = 1'b0;
        bus.halt          = 1'b0;
        bus.mem_ready     = 1'b1;
        bus.mem_data_in   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_t_cycle", 32'(bus.t_cycle), 0);
        check("rst_pc", 32'(bus.pc), 32'h0000);
        check("rst_ir", 32'(bus.instruction_register), 0);
        check("rst_valid", 32'(bus.inst_valid), 0);
        check("rst_phi", 32'(bus.clk_phi), 1);
        check("rst_mce", 32'(bus.m_cycle_end), 0);
        check("rst_ws", 32'(bus.wait_state), 0);

        // Three nominal M-cycles with Inc
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("inc_t_k%0d", k), 32'(bus.t_cycle), k % 4);
            check($sformatf("inc_pc_k%0d", k), 32'(bus.pc), k / 4);
            check($sformatf("inc_phi_k%0d", k), 32'(bus.clk_phi), ((k % 4) < 2) ? 1 : 0);
        end

        // Three wait states on the last T-cycle: 7-clock M-cycle
        clocks = 0;
        repeat (3) begin tick(); clocks++; end
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b0;
            #1;
            check($sformatf("wait_t_%0d", i), 32'(bus.t_cycle), 3);
            check($sformatf("wait_ws_%0d", i), 32'(bus.wait_state), 1);
            check($sformatf("wait_mce_%0d", i), 32'(bus.m_cycle_end), 0);
            check($sformatf("wait_phi_%0d", i), 32'(bus.clk_phi), 0);
            check($sformatf("wait_pc_%0d", i), 32'(bus.pc), 3);
            tick(); clocks++;
        end
        bus.mem_ready = 1'b1;
        #1;
        check("wait_commit_mce", 32'(bus.m_cycle_end), 1);
        check("wait_commit_ws", 32'(bus.wait_state), 0);
        tick(); clocks++;
        check("wait_after_t", 32'(bus.t_cycle), 0);
        check("wait_after_pc", 32'(bus.pc), 4);
        check("wait_mcycle_len", 32'(clocks), 7);

        // Halt before any fetch: nothing commits
        mcycle(PcNextInc, 16'h0, 8'h0, 1'b1, 8'h77, 1'b1);
        check("halt0_pc", 32'(bus.pc), 4);
        check("halt0_ir", 32'(bus.instruction_register), 0);
        check("halt0_valid", 32'(bus.inst_valid), 0);
        check("halt0_t", 32'(bus.t_cycle), 0);

        // PC modes
        mcycle(PcNextLoad, 16'h0100, 8'h0, 1'b0, 8'h0, 1'b0);
        check("load_0100", 32'(bus.pc), 32'h0100);
        mcycle(PcNextRel, 16'h0, 8'hFE, 1'b0, 8'h0, 1'b0);
        check("rel_fe", 32'(bus.pc), 32'h00FE);
        mcycle(PcNextLoad, 16'hC000, 8'h0, 1'b0, 8'h0, 1'b0);
        check("load_c000", 32'(bus.pc), 32'hC000);
        mcycle(PcNextDec, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0);
        check("dec_bfff", 32'(bus.pc), 32'hBFFF);

        // Inputs only matter on the commit edge
        bus.pc_next = PcNextLoad;
        bus.pc_load_value = 16'h1234;
        repeat (3) tick();
        bus.pc_next = PcNextSame;
        tick();
        check("offcommit_pc", 32'(bus.pc), 32'hBFFF);

        mcycle(3'd5, 16'h5555, 8'h7F, 1'b0, 8'h0, 1'b0);
        check("code5_same", 32'(bus.pc), 32'hBFFF);
        mcycle(PcNextLoad, 16'h0000, 8'h0, 1'b0, 8'h0, 1'b0);
        mcycle(PcNextDec, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0);
        check("dec_wrap", 32'(bus.pc), 32'hFFFF);
        mcycle(PcNextInc, 16'h0, 8'h0, 1'b1, 8'hCB, 1'b0);
        check("inc_wrap", 32'(bus.pc), 32'h0000);
        check("ir_cb", 32'(bus.instruction_register), 32'hCB);
        check("valid_set", 32'(bus.inst_valid), 1);
        mcycle(PcNextRel, 16'h0, 8'h80, 1'b0, 8'h0, 1'b0);
        check("rel_80_wrap", 32'(bus.pc), 32'hFF80);

        // Halt with a fetch pending
        mcycle(PcNextInc, 16'h0, 8'h0, 1'b1, 8'h3E, 1'b1);
        check("halt_pc", 32'(bus.pc), 32'hFF80);
        check("halt_ir", 32'(bus.instruction_register), 32'hCB);
        check("halt_t_wrap", 32'(bus.t_cycle), 0);

        // Reset during a wait state discards the commit
        bus.pc_next = PcNextInc;
        bus.inst_load = 1'b1;
        bus.mem_data_in = 8'h99;
        repeat (3) tick();
        bus.mem_ready = 1'b0;
        tick();
        check("prerst_ws", 32'(bus.wait_state), 1);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        check("midrst_pc", 32'(bus.pc), 32'h0000);
        check("midrst_ir", 32'(bus.instruction_register), 0);
        check("midrst_valid", 32'(bus.inst_valid), 0);
        check("midrst_t", 32'(bus.t_cycle), 0);
        check("midrst_mce", 32'(bus.m_cycle_end), 0);
        reset = 1'b0;
        bus.inst_load = 1'b0;
        tick();
        check("postrst_t", 32'(bus.t_cycle), 1);
        check("postrst_pc", 32'(bus.pc), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
